// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide datapath: Booth decode for multiply,
// restore decisions for divide, and a one-cycle ready/exception pulse on completion.
module multdiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [1:0]       last_2_bits,
    input  logic             divisor_is_zero,
    input  logic             rem_negative,
    input  logic             mult_overflow,
    output logic [1:0]       booth_op,
    output logic             div_restore,
    output logic             iter_en,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             exc_q;
    logic             last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // A start in any state restarts from cnt=0; an in-flight operation never reaches StDone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
        end else if (ctrl_MULT) begin
            state_q <= StMult;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
        end else if (ctrl_DIV) begin
            state_q <= divisor_is_zero ? StDone : StDiv;
            cnt_q   <= '0;
            exc_q   <= divisor_is_zero;
        end else begin
            unique case (state_q)
                StIdle: ;
                StMult: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        exc_q   <= mult_overflow;
                        state_q <= StDone;
                    end
                end
                StDiv: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        booth_op       = 2'b00;
        div_restore    = 1'b0;
        iter_en        = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        unique case (state_q)
            StIdle: ;
            StMult: begin
                iter_en = 1'b1;
                busy    = 1'b1;
                // Booth pair 01 adds, 10 subtracts; 00 and 11 are runs with no action.
                if (last_2_bits == 2'b01) begin
                    booth_op = 2'b01;
                end else if (last_2_bits == 2'b10) begin
                    booth_op = 2'b10;
                end
            end
            StDiv: begin
                iter_en     = 1'b1;
                busy        = 1'b1;
                div_restore = rem_negative;
            end
            StDone: begin
                data_resultRDY = 1'b1;
                data_exception = exc_q;
            end
            default: ;
        endcase
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus queues per-cycle expected outputs, a monitor
// compares them on the falling edge and flags any ready pulse nobody asked for.
module tb_multdiv_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ctrl_MULT, ctrl_DIV;
    logic [1:0]       last_2_bits;
    logic             divisor_is_zero, rem_negative, mult_overflow;
    logic [1:0]       booth_op;
    logic             div_restore, iter_en, busy, data_resultRDY, data_exception;
    logic [CNT_W-1:0] cnt;

    multdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ctrl_MULT       (ctrl_MULT),
        .ctrl_DIV        (ctrl_DIV),
        .last_2_bits     (last_2_bits),
        .divisor_is_zero (divisor_is_zero),
        .rem_negative    (rem_negative),
        .mult_overflow   (mult_overflow),
        .booth_op        (booth_op),
        .div_restore     (div_restore),
        .iter_en         (iter_en),
        .busy            (busy),
        .cnt             (cnt),
        .data_resultRDY  (data_resultRDY),
        .data_exception  (data_exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] booth;
        logic       restore;
        logic       iter;
        logic       bsy;
        logic       rdy;
        logic       exc;
        logic [5:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] b, input logic r, input logic it,
                        input logic bs, input logic rd, input logic ex, input logic [5:0] n);
        exp_t e;
        e.cyc = c; e.booth = b; e.restore = r; e.iter = it;
        e.bsy = bs; e.rdy = rd; e.exc = ex; e.count = n;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectations for this cycle; any unqueued ready is an error.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            bit had_rec;
            had_rec = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    chk("stale_expectation", e.cyc, cyc);
                end else begin
                    had_rec = 1'b1;
                    chk("booth_op", booth_op, e.booth);
                    chk("div_restore", div_restore, e.restore);
                    chk("iter_en", iter_en, e.iter);
                    chk("busy", busy, e.bsy);
                    chk("data_resultRDY", data_resultRDY, e.rdy);
                    chk("data_exception", data_exception, e.exc);
                    chk("cnt", cnt, e.count);
                end
            end
            if (!had_rec && data_resultRDY !== 1'b0) chk("unexpected_ready", data_resultRDY, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [4];
        logic [1:0] pexp [4];
        int t0;
        pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b00; pat[3] = 2'b11;
        pexp[0] = 2'b10; pexp[1] = 2'b01; pexp[2] = 2'b00; pexp[3] = 2'b00;

        reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; last_2_bits = 2'b01;
        divisor_is_zero = 1'b0; rem_negative = 1'b1; mult_overflow = 1'b0;
        #3;
        chk("rst_booth", booth_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iter", iter_en, 0);
        chk("rst_rdy", data_resultRDY, 0);
        chk("rst_cnt", cnt, 0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Multiply, Booth pattern 10,01,00,11 repeating.
        t0 = cyc; ctrl_MULT = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            ctrl_MULT = 1'b0;
            last_2_bits = pat[(k - 1) % 4];
            if (k <= 32) push(cyc, pexp[(k - 1) % 4], 0, 1, 1, 0, 0, 6'(k - 1));
            else if (k == 33) push(cyc, 0, 0, 0, 0, 1, 0, 6'd32);
            else push(cyc, 0, 0, 0, 0, 0, 0, 6'd32);
        end

        // Multiply with overflow flagged only in the last iteration.
        last_2_bits = 2'b00;
        ctrl_MULT = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            ctrl_MULT = 1'b0;
            mult_overflow = (k == 32);
            if (k <= 32) push(cyc, 0, 0, 1, 1, 0, 0, 6'(k - 1));
            else if (k == 33) push(cyc, 0, 0, 0, 0, 1, 1, 6'd32);
            else push(cyc, 0, 0, 0, 0, 0, 0, 6'd32);
        end
        mult_overflow = 1'b0;

        // Divide by zero: immediate ready with exception, no iterations.
        ctrl_DIV = 1'b1; divisor_is_zero = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            ctrl_DIV = 1'b0; divisor_is_zero = 1'b0;
            if (k == 1) push(cyc, 0, 0, 0, 0, 1, 1, 6'd0);
            else push(cyc, 0, 0, 0, 0, 0, 0, 6'd0);
        end

        // Divide, rem_negative toggling; Booth bits and overflow must be ignored.
        ctrl_DIV = 1'b1; last_2_bits = 2'b10; mult_overflow = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            ctrl_DIV = 1'b0;
            rem_negative = (k % 2 == 1);
            if (k <= 32) push(cyc, 0, (k % 2 == 1), 1, 1, 0, 0, 6'(k - 1));
            else if (k == 33) push(cyc, 0, 0, 0, 0, 1, 0, 6'd32);
            else push(cyc, 0, 0, 0, 0, 0, 0, 6'd32);
        end
        mult_overflow = 1'b0; rem_negative = 1'b0;

        // Divide aborted by a multiply start in cycle 15.
        ctrl_DIV = 1'b1; last_2_bits = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            step();
            ctrl_DIV = 1'b0;
            push(cyc, 0, 0, 1, 1, 0, 0, 6'(k - 1));
        end
        ctrl_MULT = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            ctrl_MULT = 1'b0;
            if (k <= 32) push(cyc, 2'b01, 0, 1, 1, 0, 0, 6'(k - 1));
            else if (k == 33) push(cyc, 0, 0, 0, 0, 1, 0, 6'd32);
            else push(cyc, 0, 0, 0, 0, 0, 0, 6'd32);
        end

        // Simultaneous starts: multiply wins even with a zero divisor.
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; divisor_is_zero = 1'b1; last_2_bits = 2'b10;
        for (int k = 1; k <= 33; k++) begin
            step();
            ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; divisor_is_zero = 1'b0;
            if (k <= 32) push(cyc, 2'b10, 0, 1, 1, 0, 0, 6'(k - 1));
            else push(cyc, 0, 0, 0, 0, 1, 0, 6'd32);
        end

        // Asynchronous reset mid-multiply at cnt=10.
        ctrl_MULT = 1'b1; last_2_bits = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            step();
            ctrl_MULT = 1'b0;
            push(cyc, 2'b01, 0, 1, 1, 0, 0, 6'(k - 1));
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_booth", booth_op, 0);
        chk("abort_iter", iter_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", cnt, 0);
        chk("abort_rdy", data_resultRDY, 0);
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            push(cyc, 0, 0, 0, 0, 0, 0, 6'd0);
        end

        step(); step();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit. It accepts one-cycle start pulses and steps the shared 65-bit product/remainder register datapath through WIDTH iterations. For multiply it decodes the radix-2 Booth pair to issue add, subtract or no-op each cycle; for divide it issues the restore decision each cycle. It flags completion with a one-cycle ready pulse plus an exception bit, and sits between the processor's multdiv interface and the datapath.

Parameters:
WIDTH, 32, operand width = number of iteration cycles per operation
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ctrl_MULT  input  1  start multiply; one-cycle pulse, also the datapath operand-load strobe
ctrl_DIV  input  1  start divide; one-cycle pulse
last_2_bits  input  2  Booth pair {reg[1], reg[0]} from the product register
divisor_is_zero  input  1  divisor == 0, valid in the ctrl_DIV cycle
rem_negative  input  1  sign of the divider trial subtraction, valid in DIV iterations
mult_overflow  input  1  product does not fit in WIDTH signed bits, valid in the last MULT iteration
booth_op  output  2  00 no-op, 01 add multiplicand, 10 subtract multiplicand; 11 never driven
div_restore  output  1  restore the partial remainder this cycle
iter_en  output  1  datapath shift/update enable
busy  output  1  operation in progress
cnt  output  CNT_W  current iteration index
data_resultRDY  output  1  one-cycle result-valid pulse
data_exception  output  1  overflow or divide-by-zero; valid only while data_resultRDY=1, else 0

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0; booth_op=00, div_restore=0, iter_en=0, busy=0, data_resultRDY=0, data_exception=0. Reset mid-operation aborts immediately, with no ready pulse.
- States: IDLE, MULT, DIV, DONE. Registered state and cnt; outputs are decoded from state and inputs.
- Start is sampled on the clock edge that ends a cycle with ctrl_MULT or ctrl_DIV high. This is cycle 0. A start is accepted in any state; a start while busy aborts the current operation, suppresses its ready pulse and restarts with cnt=0.
- If ctrl_MULT and ctrl_DIV are high together, multiply wins.
- Multiply start: next state MULT, cnt=0.
- MULT, cycles 1..WIDTH:
  - iter_en=1, busy=1.
  - booth_op from last_2_bits: 01 -> 01 (add), 10 -> 10 (sub), 00/11 -> 00.
  - cnt increments each cycle.
  - At cnt==WIDTH-1, mult_overflow is captured into an exception flop and the next state is DONE.
- Divide start with divisor_is_zero=1: next state DONE, exception flop=1, no iterations. Ready appears in cycle 1.
- Divide start with divisor_is_zero=0: next state DIV, cnt=0, exception flop=0.
- DIV, cycles 1..WIDTH: iter_en=1, busy=1, div_restore=rem_negative, booth_op=00. At cnt==WIDTH-1 the next state is DONE.
- DONE, one cycle:
  - data_resultRDY=1, data_exception=exception flop.
  - busy=0, iter_en=0.
  - Next state is IDLE, or MULT/DIV if a start arrives in this cycle.
- Normal latency: data_resultRDY in cycle WIDTH+1 (33 at default).
- cnt holds its last value in DONE and IDLE; it is cleared only by a start or reset.
- Outside MULT, booth_op=00. Outside DIV, div_restore=0.

Test Plan:
- Reset asserted asynchronously mid-MULT at cnt=10 -> all outputs 0 immediately, state IDLE; no data_resultRDY within the next 40 cycles.
- ctrl_MULT pulse, last_2_bits driven 10,01,00,11 repeating, mult_overflow=0 -> booth_op 10,01,00,00 repeating in cycles 1..32; busy=1 in cycles 1..32; data_resultRDY=1 with data_exception=0 in cycle 33 only.
- ctrl_MULT with mult_overflow=1 only in cycle 32 -> data_exception=1 in cycle 33; data_exception=0 in cycle 34.
- ctrl_DIV with divisor_is_zero=1 -> data_resultRDY=1 and data_exception=1 in cycle 1; iter_en never asserted.
- ctrl_DIV with divisor_is_zero=0, rem_negative toggling each cycle -> div_restore follows rem_negative in cycles 1..32; ready in cycle 33 with data_exception=0.
- ctrl_DIV, then ctrl_MULT at cycle 15 -> no ready for the divide; MULT restarts with cnt=0 and ready appears 33 cycles after the ctrl_MULT pulse. Separately, ctrl_MULT and ctrl_DIV in the same cycle -> multiply sequence runs.
